regfile_writeback: RTL
======================

# regfile_writeback

Writeback buffer between the execute/memory stages and the `Registers` write port. Results arrive through a valid/ready handshake, queue in a small in-order FIFO, and retire to the register file at one write per cycle on registered outputs. Two combinational forwarding lookups return the youngest pending value for any register still in flight. The decode stage can therefore read correct operands before the register file itself has been updated.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `DATA_W`, 32, result width.
- `ADDR_W`, 5, register index width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a result.
- `in_ready`  out  1  buffer can accept a result this cycle.
- `in_addr`  in  ADDR_W  destination register.
- `in_data`  in  DATA_W  result value.
- `rf_we_addr`  out  ADDR_W  register-file write address (registered).
- `rf_wdata`  out  DATA_W  register-file write data (registered).
- `rf_write`  out  1  register-file write strobe (registered).
- `fwd_rs`, `fwd_ra`  in  ADDR_W  lookup indices (decode operand fields).
- `fwd_rs_hit`, `fwd_ra_hit`  out  1  a pending write to that index exists.
- `fwd_rs_data`, `fwd_ra_data`  out  DATA_W  youngest pending value; 0 when there is no hit.
- `empty`  out  1  the FIFO holds no entries and `rf_write` is 0.

## Operation
- **Storage:** circular FIFO with `wr_ptr`, `rd_ptr` and `count` (width log2(DEPTH)+1). Pointers wrap modulo DEPTH.
- **Accept:** an entry is accepted when `in_valid && in_ready`.
  - `in_ready = !rst && (count < DEPTH)`. It is computed from registered state only and never depends on `in_valid`.
- **Register 0:** an accepted entry with `in_addr == 0` completes the handshake but is discarded. It is not stored, `count` is unchanged and it is never written.
- **Retire:** each cycle, if `count > 0`, the head entry is popped and loaded into `rf_we_addr`/`rf_wdata` with `rf_write=1`. If `count == 0`, `rf_write=0` and `rf_we_addr`/`rf_wdata` hold their previous values.
- **Push and pop in the same edge:**
  - Both happen; `count` is unchanged.
  - When full, `in_ready=0`, so no push happens that cycle. There is no pass-through on full.
  - When empty, a push enters the FIFO. It does not go directly to `rf_*`.
- **Forwarding:** the candidate set is the valid FIFO entries plus the output stage while `rf_write=1`.
  - Priority, youngest first: newest FIFO entry (`wr_ptr-1`) back to the head, then the output stage.
  - Indices equal to 0 never hit.
  - An entry being accepted this cycle is not visible to the lookup until the next cycle.
  - The lookup is purely combinational from registered state.
- **Ordering:** writes retire in acceptance order. Consecutive writes to the same register all retire, and the last one wins in the register file.

## Timing
- **Reset:** while `rst` is high at an edge, the next state is:
  - `count=0`, `wr_ptr=rd_ptr=0`
  - `rf_write=0`, `rf_we_addr=0`, `rf_wdata=0`
  - outputs `in_ready=0`, all `*_hit=0`, `*_data=0`, `empty=1`
  - FIFO contents are don't-care.
- **Reset mid-operation:** all pending entries are dropped and no write is issued. The handshake is refused during any cycle where `rst` is high.
- **Latency:** a result accepted at edge k is on `rf_*` with `rf_write=1` after edge k+1, provided it is at the head. The `Registers` block commits it at edge k+2.
- **Forwarding window:** from the cycle after acceptance, edge k+1, through the cycle `rf_write` presents it, up to edge k+2.
- **Throughput:** sustained one result per cycle. In steady state with continuous input, `count` stays at 1.
- **Full:** `in_ready` drops in the cycle where `count == DEPTH` and returns the cycle after the next pop.

## Test plan
- **Reset:**
  - Stimulus: hold `rst=1` for 2 cycles with `in_valid=1`.
  - Required: `in_ready=0`, `rf_write=0`, `empty=1`.
  - After release: `in_ready=1` on the first cycle.
- **Single write:**
  - Stimulus: accept (addr 5, data 0x0000_00AA) at edge k.
  - Required: after edge k+1, `rf_write=1`, `rf_we_addr=5`, `rf_wdata=0xAA` for exactly one cycle.
  - Required: `fwd_rs=5` hits with 0xAA from edge k+1 until edge k+2.
- **Youngest forwarding:**
  - Setup: stall retire by preloading 3 back-to-back entries in the same cycle window.
  - Stimulus: accept (7,0x11), (7,0x22), (3,0x33) on consecutive edges.
  - Required: `fwd_ra=7` returns 0x22 while both entries are pending.
  - Required: the `rf_*` sequence is 7/0x11, 7/0x22, 3/0x33.
- **Register 0:**
  - Stimulus: accept (0, 0xDEAD_BEEF).
  - Required: the handshake completes, `rf_write` never asserts, `empty` stays 1, and `fwd_rs=0` never hits.
- **Full/back-pressure:**
  - Setup: DEPTH=4 with a forced stall, using a bench-only force on the pop.
  - Stimulus: fill 4 entries, then assert a 5th `in_valid`.
  - Required: `in_ready=0` until one entry pops; the 5th entry is accepted the following cycle; no loss and no duplication.
- **Reset mid-stream:**
  - Stimulus: 3 entries pending, pulse `rst` for one edge.
  - Required: next cycle `rf_write=0`, `empty=1`, no hits, and no write of the old entries ever appears.

Source files
------------

// File: rtl/regfile_writeback.sv
// Writeback buffer: in-order FIFO of results retiring one per cycle to the register-file
// write port, with two combinational forwarding lookups over all in-flight writes.
module regfile_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] rf_we_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_write,
    input  logic [ADDR_W-1:0] fwd_rs,
    input  logic [ADDR_W-1:0] fwd_ra,
    output logic              fwd_rs_hit,
    output logic              fwd_ra_hit,
    output logic [DATA_W-1:0] fwd_rs_data,
    output logic [DATA_W-1:0] fwd_ra_data,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0] r_rf_data;
    logic              r_rf_write;

    // Retire enable is a single named net so a stall can be imposed from outside in simulation.
    wire               w_pop_en;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [PW-1:0]     w_idx;
    logic              w_rs_hit;
    logic              w_ra_hit;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_ra_data;

    assign w_pop_en = 1'b1;
    assign in_ready = !rst && (r_count < FULL_CNT);
    assign w_accept = in_valid && in_ready;
    // Writes to register 0 complete the handshake but are dropped.
    assign w_push   = w_accept && (in_addr != '0);
    assign w_pop    = w_pop_en && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= in_addr;
            r_mem_data[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rf_addr  <= '0;
            r_rf_data  <= '0;
            r_rf_write <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rf_addr  <= r_mem_addr[r_rd_ptr];
                r_rf_data  <= r_mem_data[r_rd_ptr];
                r_rf_write <= 1'b1;
                r_rd_ptr   <= r_rd_ptr + PW'(1);
            end else begin
                r_rf_write <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Scan oldest to youngest so the last match, the youngest pending write, wins.
    always_comb begin
        w_rs_hit  = 1'b0;
        w_ra_hit  = 1'b0;
        w_rs_data = '0;
        w_ra_data = '0;
        w_idx     = r_rd_ptr;
        if (r_rf_write) begin
            if ((fwd_rs != '0) && (r_rf_addr == fwd_rs)) begin
                w_rs_hit  = 1'b1;
                w_rs_data = r_rf_data;
            end
            if ((fwd_ra != '0) && (r_rf_addr == fwd_ra)) begin
                w_ra_hit  = 1'b1;
                w_ra_data = r_rf_data;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PW'(i);
            if (CW'(i) < r_count) begin
                if ((fwd_rs != '0) && (r_mem_addr[w_idx] == fwd_rs)) begin
                    w_rs_hit  = 1'b1;
                    w_rs_data = r_mem_data[w_idx];
                end
                if ((fwd_ra != '0) && (r_mem_addr[w_idx] == fwd_ra)) begin
                    w_ra_hit  = 1'b1;
                    w_ra_data = r_mem_data[w_idx];
                end
            end
        end
    end

    assign fwd_rs_hit  = w_rs_hit;
    assign fwd_ra_hit  = w_ra_hit;
    assign fwd_rs_data = w_rs_data;
    assign fwd_ra_data = w_ra_data;
    assign rf_we_addr  = r_rf_addr;
    assign rf_wdata    = r_rf_data;
    assign rf_write    = r_rf_write;
    assign empty       = (r_count == '0) && !r_rf_write;

endmodule
